// File: rtl/fetch_pkg.sv
// Shared types, geometry and BTB address helpers for the fetch next-PC slice.
// XLEN and BTB depth are fixed here; the top checks its parameters against them.
package fetch_pkg;

    localparam int FETCH_XLEN        = 32;
    localparam int FETCH_BTB_ENTRIES = 16;
    localparam int IDXW              = $clog2(FETCH_BTB_ENTRIES);
    localparam int TAGW              = FETCH_XLEN - IDXW - 2;

    localparam logic [FETCH_XLEN-1:0] INSN_BYTES = 32'd4;

    typedef struct packed {
        logic                  valid;
        logic [TAGW-1:0]       tag;
        logic [FETCH_XLEN-1:0] target;
    } btb_entry_t;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [IDXW-1:0] btb_index(input logic [FETCH_XLEN-1:0] pc);
        return pc[IDXW+1:2];
    endfunction

    function automatic logic [TAGW-1:0] btb_tag(input logic [FETCH_XLEN-1:0] pc);
        return pc[FETCH_XLEN-1:IDXW+2];
    endfunction

endpackage

// File: rtl/fetch_next_pc_btb_dm.sv
// Direct-mapped BTB: combinational read, synchronous write, async clear of valid bits.
// Tags and targets are left unreset; the valid bits alone gate a hit.
module btb_dm
    import fetch_pkg::*;
#(
    parameter int ENTRIES = FETCH_BTB_ENTRIES
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IDXW-1:0] rd_idx,
    output btb_entry_t      rd_entry,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  btb_entry_t      wr_entry
);

    logic [ENTRIES-1:0]    valid_q;
    logic [ENTRIES-1:0]    valid_d;
    logic [TAGW-1:0]       tag_q    [ENTRIES];
    logic [FETCH_XLEN-1:0] target_q [ENTRIES];

    // Next valid vector: set the written slot, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_entry.valid;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits: the only BTB state cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/target payload, written only on a taken-branch update.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_entry.tag;
            target_q[wr_idx] <= wr_entry.target;
        end
    end

    assign rd_entry = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx], target: target_q[rd_idx]};

endmodule

// File: rtl/fetch_next_pc.sv
// Fetch-stage next-PC generator: PC register, BOOT/RUN sequencing, BTB-based
// prediction, execute-stage mispredict redirect and predictor training taps.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int              XLEN        = FETCH_XLEN,
    parameter int              BTB_ENTRIES = FETCH_BTB_ENTRIES,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_prediction,
    input  logic            ex_branch_valid,
    input  logic [XLEN-1:0] ex_branch_pc,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_valid,
    output logic            fetch_pred_taken,
    output logic [XLEN-1:0] fetch_pred_target,
    output logic            flush,
    output logic            take_branch,
    output logic            brancher_valid
);

    if ((XLEN != FETCH_XLEN) || (BTB_ENTRIES != FETCH_BTB_ENTRIES)) begin : g_cfg_check
        $error("fetch_next_pc geometry must match fetch_pkg");
    end

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_s;
    logic            take_branch_q;
    logic            brancher_valid_q;
    logic            hit_s;
    logic            mispredict_s;
    logic            btb_wr_s;
    btb_entry_t      rd_entry_s;
    btb_entry_t      wr_entry_s;

    assign pc_plus4_s = pc_q + INSN_BYTES;
    assign btb_wr_s   = ex_branch_valid && ex_branch_taken;
    assign wr_entry_s = '{valid: 1'b1, tag: btb_tag(ex_branch_pc), target: ex_branch_target};

    btb_dm #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (btb_index(pc_q)),
        .rd_entry (rd_entry_s),
        .wr_en    (btb_wr_s),
        .wr_idx   (btb_index(ex_branch_pc)),
        .wr_entry (wr_entry_s)
    );

    // BTB lookup on the current fetch PC (pre-write contents on a same-cycle update).
    always_comb begin
        hit_s            = rd_entry_s.valid && (rd_entry_s.tag == btb_tag(pc_q));
        fetch_pred_taken = hit_s && branch_prediction;
        if (hit_s) begin
            fetch_pred_target = rd_entry_s.target;
        end else begin
            fetch_pred_target = pc_plus4_s;
        end
    end

    // Mispredict detection, flush and fetch validity.
    always_comb begin
        mispredict_s = ex_branch_valid &&
                       ((ex_branch_taken != ex_pred_taken) ||
                        (ex_branch_taken && (ex_branch_target != ex_pred_target)));
        flush        = mispredict_s && (state_q == RUN);
        fetch_valid  = (state_q == RUN) && !stall && !flush;
    end

    // Next PC priority: redirect, stall, BOOT hold, predicted taken, sequential.
    always_comb begin
        pc_d = pc_plus4_s;
        if (mispredict_s) begin
            if (ex_branch_taken) begin
                pc_d = ex_branch_target;
            end else begin
                pc_d = ex_branch_pc + INSN_BYTES;
            end
        end else if (stall || (state_q == BOOT)) begin
            pc_d = pc_q;
        end else if (fetch_pred_taken) begin
            pc_d = fetch_pred_target;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // BOOT lasts exactly one cycle.
    always_comb begin
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // PC, state and predictor-training registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            state_q          <= BOOT;
            take_branch_q    <= 1'b0;
            brancher_valid_q <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            state_q          <= state_d;
            take_branch_q    <= ex_branch_taken;
            brancher_valid_q <= ex_branch_valid;
        end
    end

    assign fetch_pc       = pc_q;
    assign take_branch    = take_branch_q;
    assign brancher_valid = brancher_valid_q;

endmodule

// File: tb/tb_fetch_next_pc.sv
// Directed scoreboard bench for fetch_next_pc: expectations are queued as each
// step is driven and popped against the DUT outputs half a cycle later.
module tb_fetch_next_pc;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_prediction;
    logic        ex_branch_valid;
    logic [31:0] ex_branch_pc;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_target;
    logic        flush;
    logic        take_branch;
    logic        brancher_valid;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    fetch_next_pc dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .branch_prediction (branch_prediction),
        .ex_branch_valid   (ex_branch_valid),
        .ex_branch_pc      (ex_branch_pc),
        .ex_branch_taken   (ex_branch_taken),
        .ex_branch_target  (ex_branch_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .fetch_pc          (fetch_pc),
        .fetch_valid       (fetch_valid),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .flush             (flush),
        .take_branch       (take_branch),
        .brancher_valid    (brancher_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_branch_valid  = v;
        ex_branch_pc     = pc;
        ex_branch_taken  = tk;
        ex_branch_target = tgt;
        ex_pred_taken    = ptk;
        ex_pred_target   = ptgt;
    endtask

    // Not-taken mispredict from (target - 4): a cheap way to steer fetch_pc.
    task automatic steer(input logic [31:0] target);
        drive_ex(1'b1, target - 32'd4, 1'b0, 32'd0, 1'b1, 32'h0000_0040);
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        stall = 1'b0;
        branch_prediction = 1'b0;
        idle_ex();

        // Reset state.
        #2;
        expect_val("rst_pc", 32'h0);
        expect_val("rst_valid", 32'd0);
        expect_val("rst_flush", 32'd0);
        expect_val("rst_take", 32'd0);
        expect_val("rst_bvalid", 32'd0);
        check(fetch_pc);
        check({31'd0, fetch_valid});
        check({31'd0, flush});
        check({31'd0, take_branch});
        check({31'd0, brancher_valid});

        // BOOT cycle after release.
        #10;
        reset = 1'b0;
        #1;
        expect_val("boot_valid", 32'd0);
        check({31'd0, fetch_valid});

        // Sequential fetch 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            expect_val("seq_pc", 32'(i * 4));
            expect_val("seq_valid", 32'd1);
            expect_val("seq_bvalid", 32'd0);
            check(fetch_pc);
            check({31'd0, fetch_valid});
            check({31'd0, brancher_valid});
        end

        // Train BTB: 0x10 taken to 0x80, predicted not taken.
        drive_ex(1'b1, 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        expect_val("train_flush", 32'd1);
        expect_val("train_valid", 32'd0);
        check({31'd0, flush});
        check({31'd0, fetch_valid});

        @(negedge clock);
        idle_ex();
        #1;
        expect_val("redir_pc", 32'h80);
        expect_val("redir_valid", 32'd1);
        expect_val("redir_take", 32'd1);
        expect_val("redir_bvalid", 32'd1);
        expect_val("redir_flush", 32'd0);
        check(fetch_pc);
        check({31'd0, fetch_valid});
        check({31'd0, take_branch});
        check({31'd0, brancher_valid});
        check({31'd0, flush});

        // Steer to 0x10.
        @(negedge clock);
        steer(32'h10);
        #1;
        expect_val("steer_pc", 32'h84);
        expect_val("steer_flush", 32'd1);
        check(fetch_pc);
        check({31'd0, flush});

        // Hit at 0x10 with prediction taken.
        @(negedge clock);
        idle_ex();
        branch_prediction = 1'b1;
        #1;
        expect_val("hit_pc", 32'h10);
        expect_val("hit_take_nt", 32'd0);
        expect_val("hit_pred_taken", 32'd1);
        expect_val("hit_pred_target", 32'h80);
        check(fetch_pc);
        check({31'd0, take_branch});
        check({31'd0, fetch_pred_taken});
        check(fetch_pred_target);

        // Followed to 0x80; mispredict under stall redirects to 0x14.
        @(negedge clock);
        branch_prediction = 1'b0;
        stall = 1'b1;
        drive_ex(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        expect_val("follow_pc", 32'h80);
        expect_val("stall_mp_flush", 32'd1);
        expect_val("stall_mp_valid", 32'd0);
        check(fetch_pc);
        check({31'd0, flush});
        check({31'd0, fetch_valid});

        @(negedge clock);
        stall = 1'b0;
        steer(32'h10);
        #1;
        expect_val("stall_mp_pc", 32'h14);
        check(fetch_pc);

        // Hit at 0x10 with prediction not taken.
        @(negedge clock);
        idle_ex();
        #1;
        expect_val("nt_pc", 32'h10);
        expect_val("nt_pred_taken", 32'd0);
        expect_val("nt_pred_target", 32'h80);
        check(fetch_pc);
        check({31'd0, fetch_pred_taken});
        check(fetch_pred_target);

        // Sequential to 0x14, then stall holds it.
        @(negedge clock);
        stall = 1'b1;
        #1;
        expect_val("nt_next_pc", 32'h14);
        expect_val("stall_valid", 32'd0);
        check(fetch_pc);
        check({31'd0, fetch_valid});

        @(negedge clock);
        stall = 1'b0;
        drive_ex(1'b1, 32'h50, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        expect_val("stall_hold_pc", 32'h14);
        check(fetch_pc);

        // Alias: 0x50 overwrote index 4.
        @(negedge clock);
        steer(32'h10);
        #1;
        expect_val("alias_redir_pc", 32'h200);
        check(fetch_pc);

        @(negedge clock);
        branch_prediction = 1'b1;
        steer(32'h50);
        #1;
        expect_val("alias_miss_taken", 32'd0);
        expect_val("alias_miss_target", 32'h14);
        check({31'd0, fetch_pred_taken});
        check(fetch_pred_target);

        @(negedge clock);
        idle_ex();
        #1;
        expect_val("alias_hit_pc", 32'h50);
        expect_val("alias_hit_taken", 32'd1);
        expect_val("alias_hit_target", 32'h200);
        check(fetch_pc);
        check({31'd0, fetch_pred_taken});
        check(fetch_pred_target);

        @(negedge clock);
        branch_prediction = 1'b0;
        steer(32'hFFFF_FFFC);
        #1;
        expect_val("alias_follow_pc", 32'h200);
        check(fetch_pc);

        // pc+4 wraps at the top of the address space.
        @(negedge clock);
        idle_ex();
        #1;
        expect_val("wrap_pc", 32'hFFFF_FFFC);
        expect_val("wrap_target", 32'h0);
        check(fetch_pc);
        check(fetch_pred_target);

        @(negedge clock);
        steer(32'h80);
        #1;
        expect_val("wrap_next_pc", 32'h0);
        check(fetch_pc);

        // Async reset mid-stall at pc 0x80.
        @(negedge clock);
        idle_ex();
        stall = 1'b1;
        #1;
        expect_val("pre_rst_pc", 32'h80);
        check(fetch_pc);
        #1;
        reset = 1'b1;
        #1;
        expect_val("async_rst_pc", 32'h0);
        expect_val("async_rst_valid", 32'd0);
        check(fetch_pc);
        check({31'd0, fetch_valid});
        #4;
        reset = 1'b0;
        stall = 1'b0;

        // BTB cleared: 0x10 misses after reset.
        @(negedge clock);
        steer(32'h10);
        #1;
        @(negedge clock);
        idle_ex();
        branch_prediction = 1'b1;
        #1;
        expect_val("post_rst_pc", 32'h10);
        expect_val("post_rst_taken", 32'd0);
        expect_val("post_rst_target", 32'h14);
        check(fetch_pc);
        check({31'd0, fetch_pred_taken});
        check(fetch_pred_target);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
